// File: rtl/targ_btb_assoc.sv
// Tagged set-associative branch target buffer with multi-port lookup,
// confidence-based training, round-robin replacement and set-wise invalidation.
module targ_btb_assoc #(
    parameter int PORT_CNT = 3,
    parameter int SETS     = 32,
    parameter int WAYS     = 2,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 12,
    parameter int CONF_W   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             flush,
    input  logic [PORT_CNT-1:0]              req_valid,
    input  logic [PORT_CNT-1:0][ADDR_W-1:0]  req_addr,
    output logic [PORT_CNT-1:0]              rsp_valid,
    output logic [PORT_CNT-1:0]              rsp_hit,
    output logic [PORT_CNT-1:0][ADDR_W-1:0]  rsp_targ,
    output logic [PORT_CNT-1:0][CONF_W-1:0]  rsp_conf,
    input  logic                             fb_valid,
    input  logic [ADDR_W-1:0]                fb_addr,
    input  logic [ADDR_W-1:0]                fb_targ,
    input  logic                             fb_taken,
    output logic                             busy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CONF_W-1:0] CONF_MAX = '1;
    localparam logic [CONF_W-1:0] CONF_ONE = CONF_W'(1);
    localparam logic [IDX_W-1:0]  LAST_SET = IDX_W'(SETS - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     clr_q, clr_d;
    logic                 init, ready;

    logic [WAYS-1:0]      vld_q  [SETS];
    logic [TAG_W-1:0]     tag_q  [SETS][WAYS];
    logic [ADDR_W-1:0]    targ_q [SETS][WAYS];
    logic [CONF_W-1:0]    conf_q [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q   [SETS];

    logic [IDX_W-1:0]     req_idx [PORT_CNT];
    logic [TAG_W-1:0]     req_tag [PORT_CNT];

    logic [PORT_CNT-1:0]             rsp_valid_q, rsp_valid_d;
    logic [PORT_CNT-1:0]             rsp_hit_q, rsp_hit_d;
    logic [PORT_CNT-1:0][ADDR_W-1:0] rsp_targ_q, rsp_targ_d;
    logic [PORT_CNT-1:0][CONF_W-1:0] rsp_conf_q, rsp_conf_d;

    logic [IDX_W-1:0]     fb_idx;
    logic [TAG_W-1:0]     fb_tag;
    logic                 fb_hit, fb_free;
    logic [WAY_W-1:0]     hit_way, free_way;
    logic [ADDR_W-1:0]    cur_targ;
    logic [CONF_W-1:0]    cur_conf;
    logic                 trn;
    logic                 wr_en, wr_vld, rr_adv;
    logic [WAY_W-1:0]     wr_way;
    logic [ADDR_W-1:0]    wr_targ;
    logic [CONF_W-1:0]    wr_conf;

    // Address bits outside index and tag do not take part in the lookup.
    logic                 unused_bits;
    assign unused_bits = ^{req_addr, fb_addr};

    assign init  = (state_q == S_INIT);
    assign ready = (state_q == S_READY);
    assign busy  = init;

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_targ  = rsp_targ_q;
    assign rsp_conf  = rsp_conf_q;

    assign fb_idx = fb_addr[IDX_W+1:2];
    assign fb_tag = fb_addr[IDX_W+2+TAG_W-1:IDX_W+2];

    // Sequencer state and invalidation set counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Walk every set once, then serve; flush restarts the walk.
    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            S_INIT: begin
                if (flush) begin
                    clr_d = '0;
                end else if (clr_q == LAST_SET) begin
                    state_d = S_READY;
                    clr_d   = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            S_READY: begin
                if (flush) begin
                    state_d = S_INIT;
                    clr_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                clr_d   = '0;
            end
        endcase
    end

    // Split each lookup PC into set index and tag.
    always_comb begin
        for (int p = 0; p < PORT_CNT; p++) begin
            req_idx[p] = req_addr[p][IDX_W+1:2];
            req_tag[p] = req_addr[p][IDX_W+2+TAG_W-1:IDX_W+2];
        end
    end

    // Per-port tag match; scanning downwards lets the lowest way win.
    always_comb begin
        rsp_valid_d = '0;
        rsp_hit_d   = '0;
        rsp_targ_d  = '0;
        rsp_conf_d  = '0;
        for (int p = 0; p < PORT_CNT; p++) begin
            rsp_valid_d[p] = req_valid[p] & en & ready;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (rsp_valid_d[p] && vld_q[req_idx[p]][w] &&
                    tag_q[req_idx[p]][w] == req_tag[p]) begin
                    rsp_hit_d[p]  = 1'b1;
                    rsp_targ_d[p] = targ_q[req_idx[p]][w];
                    rsp_conf_d[p] = conf_q[req_idx[p]][w];
                end
            end
        end
    end

    // Registered response stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_hit_q   <= '0;
            rsp_targ_q  <= '0;
            rsp_conf_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_targ_q  <= rsp_targ_d;
            rsp_conf_q  <= rsp_conf_d;
        end
    end

    // Feedback set probe: matching way and lowest free way.
    always_comb begin
        fb_hit   = 1'b0;
        fb_free  = 1'b0;
        hit_way  = '0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[fb_idx][w] && tag_q[fb_idx][w] == fb_tag) begin
                fb_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!vld_q[fb_idx][w]) begin
                fb_free  = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        cur_targ = targ_q[fb_idx][hit_way];
        cur_conf = conf_q[fb_idx][hit_way];
    end

    // Training decision: confidence update, retarget or allocation.
    always_comb begin
        trn     = fb_valid & en & ready;
        wr_en   = 1'b0;
        wr_vld  = 1'b1;
        wr_way  = hit_way;
        wr_targ = cur_targ;
        wr_conf = cur_conf;
        rr_adv  = 1'b0;
        if (trn && fb_hit) begin
            wr_en = 1'b1;
            if (fb_taken && fb_targ == cur_targ) begin
                if (cur_conf != CONF_MAX) begin
                    wr_conf = cur_conf + 1'b1;
                end
            end else if (fb_taken) begin
                if (cur_conf > CONF_ONE) begin
                    wr_conf = cur_conf - 1'b1;
                end else begin
                    wr_targ = fb_targ;
                    wr_conf = CONF_ONE;
                end
            end else begin
                wr_conf = (cur_conf != '0) ? cur_conf - 1'b1 : '0;
                wr_vld  = (cur_conf > CONF_ONE);
            end
        end else if (trn && fb_taken) begin
            wr_en   = 1'b1;
            wr_targ = fb_targ;
            wr_conf = CONF_ONE;
            if (fb_free) begin
                wr_way = free_way;
            end else begin
                wr_way = rr_q[fb_idx];
                rr_adv = (WAYS > 1);
            end
        end
    end

    // Table storage: invalidation walk or single-way training write.
    always_ff @(posedge clk) begin
        if (!rst && init) begin
            vld_q[clr_q] <= '0;
            rr_q[clr_q]  <= '0;
        end else if (!rst && wr_en) begin
            vld_q[fb_idx][wr_way]  <= wr_vld;
            tag_q[fb_idx][wr_way]  <= fb_tag;
            targ_q[fb_idx][wr_way] <= wr_targ;
            conf_q[fb_idx][wr_way] <= wr_conf;
            if (rr_adv) begin
                rr_q[fb_idx] <= rr_q[fb_idx] + 1'b1;
            end
        end
    end

endmodule

// File: doc/targ_btb_assoc.md
Name: targ_btb_assoc

Overview:
- Next-generation branch target predictor: tagged, set-associative BTB serving PORT_CNT parallel fetch lookups per cycle.
- Has a registered response stage, feedback-driven training with saturating confidence, per-set round-robin replacement, and a set-by-set invalidation sequencer on reset and flush.
- Sits between the fetch-stage PC generators and the branch-resolution feedback path in core.

Parameters:
- PORT_CNT, 3, number of independent lookup ports.
- SETS, 32, number of sets; power of 2, >=2. IDX_W = $clog2(SETS).
- WAYS, 2, associativity; power of 2, 1..8.
- ADDR_W, 32, address and target width.
- TAG_W, 12, stored tag bits.
- CONF_W, 2, confidence counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable; gates lookups and training.
- flush  in  1  one-cycle pulse; invalidates the whole table.
- req_valid  in  [PORT_CNT]  lookup request valid, per port.
- req_addr  in  [PORT_CNT][ADDR_W]  lookup PC, per port.
- rsp_valid  out  [PORT_CNT]  response valid, one cycle after the request.
- rsp_hit  out  [PORT_CNT]  tag hit on a valid entry.
- rsp_targ  out  [PORT_CNT][ADDR_W]  predicted target.
- rsp_conf  out  [PORT_CNT][CONF_W]  confidence of the hit entry.
- fb_valid  in  1  resolved branch feedback valid.
- fb_addr  in  ADDR_W  branch PC.
- fb_targ  in  ADDR_W  resolved target.
- fb_taken  in  1  branch resolved taken.
- busy  out  1  invalidation sequence in progress.

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[IDX_W+2+TAG_W-1:IDX_W+2]. Bits [1:0] are ignored.
- Entry fields: valid, tag, targ, conf. Each set holds a round-robin pointer rr of log2(WAYS) bits (absent when WAYS=1).
- FSM states INIT and READY.
  - rst=1: next state INIT, clr_ctr=0; all outputs 0 next cycle.
  - INIT: each cycle clears valid of every way in set clr_ctr and sets rr=0. clr_ctr increments. After set SETS-1 is cleared, go to READY. Takes exactly SETS cycles.
  - busy=1 throughout INIT.
  - flush in READY: go to INIT with clr_ctr=0.
  - flush in INIT: restart clr_ctr at 0.
- Lookup, 1-cycle latency:
  - rsp_valid[i] <= req_valid[i] & en & READY.
  - Hit: any way with valid and tag match. The lowest-index matching way wins; a duplicate match cannot arise via training.
  - On hit: rsp_hit=1, rsp_targ and rsp_conf from that way.
  - On miss or rsp_valid=0: rsp_hit, rsp_targ and rsp_conf are 0.
  - Ports are fully independent. Several ports may address the same set in one cycle.
- Training: applied at the clock edge when fb_valid & en & READY. Ignored otherwise, including during INIT.
  - Hit, taken, fb_targ == stored targ: conf saturating increment (max 2^CONF_W-1).
  - Hit, taken, target differs: if conf > 1, decrement conf. If conf <= 1, replace targ with fb_targ and set conf=1.
  - Hit, not taken: decrement conf. If conf reaches 0, clear valid.
  - Miss, taken: allocate the lowest-index invalid way if one exists; otherwise way rr, then rr <= rr+1 (wraps). Write valid=1, tag, targ=fb_targ, conf=1. rr advances only when an evicting allocation occurs.
  - Miss, not taken: no change.
- Ordering: a lookup and training to the same set in the same cycle return the pre-update contents; there is no bypass. The update is visible to lookups issued the following cycle.
- en=0: no lookups, no training, table contents held. The INIT sequence still runs while en=0.
- Reset mid-INIT or mid-operation restarts INIT from set 0. Table contents are never otherwise initialised.

Test Plan:
- Reset with SETS=32: busy=1 for exactly 32 cycles, then 0. Lookup of 0x1000 on all 3 ports -> rsp_valid=3'b111, rsp_hit=0, rsp_targ=0.
- Feedback fb_addr=0x1000, fb_targ=0x2000, taken. Next-cycle lookup 0x1000 -> hit, targ 0x2000, conf 1. Two more identical feedbacks -> conf 3; a third -> conf stays 3.
- Entry at conf 1, feedback with the same PC not taken -> valid cleared; subsequent lookup misses.
- Entry with conf 3, taken feedback with fb_targ=0x3000 -> conf 2, targ stays 0x2000. Repeat twice more -> targ 0x3000, conf 1.
- WAYS=2: allocate three PCs mapping to set 0 with distinct tags (0x0000, 0x8000, 0x10000). The third evicts way 0 (rr=0 -> 1). A fourth PC evicts way 1.
- Same-cycle lookup and first allocation of 0x1000 -> response misses, next-cycle lookup hits. Flush pulse -> busy for 32 cycles, feedback ignored during it, all lookups miss afterwards.
